cpu_run_monitor: RTL and testbench

- Downstream observer of mips_cpu_harvard in the per-instruction test benches. Consumes the CPU's instr_address, active and register_v0 outputs.
- Detects program start at the reset vector and halt at address 0. Counts cycles and fetches, and enforces a timeout.
- Captures the final v0 and compares it with an expected value. Produces sticky done/pass/fail flags for the bench, replacing ad-hoc negedge asserts.

---
 rtl/mon_pkg.sv | 9 +
 rtl/sat_counter.sv | 26 ++
 rtl/cpu_run_monitor.sv | 153 +++++++++++++++
 tb/tb_cpu_run_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared types and default addresses for the CPU run monitor.
package mon_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CHECK, DONE} state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at all-ones; clr reloads with the inc bit so a
// start cycle can count itself.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (en) begin
      if (clr) begin
        q <= {{(W-1){1'b0}}, inc};
      end else if (inc && (q != '1)) begin
        q <= q + {{(W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Watches a CPU's fetch stream from reset vector to halt, counts cycles and
// fetches, enforces timeout/drain limits and grades the final v0.
module cpu_run_monitor
  import mon_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR      = DEFAULT_HALT_ADDR,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             active,
  input  logic [31:0]      instr_address,
  input  logic [31:0]      register_v0,
  input  logic [31:0]      expected_v0,
  input  logic             check_en,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             halt_err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] fetch_count,
  output logic [31:0]      final_v0
);

  state_t           state_q, state_d;
  logic [31:0]      prev_addr_q, prev_addr_d, final_v0_d;
  logic             done_d, pass_d, fail_d, timeout_d, halt_err_d;
  logic [CNT_W-1:0] drain_count;
  logic             start, halt_hit, timeout_hit, drain_last, new_fetch;
  logic             cyc_clr, cyc_inc, fetch_clr, fetch_inc, drain_clr, drain_inc;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk(clk), .reset(reset), .en(clk_enable), .clr(cyc_clr), .inc(cyc_inc), .q(cycle_count)
  );
  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk(clk), .reset(reset), .en(clk_enable), .clr(fetch_clr), .inc(fetch_inc), .q(fetch_count)
  );
  sat_counter #(.W(CNT_W)) u_drain_cnt (
    .clk(clk), .reset(reset), .en(clk_enable), .clr(drain_clr), .inc(drain_inc), .q(drain_count)
  );

  // Next state, next registered outputs and counter controls.
  always_comb begin
    state_d     = state_q;
    prev_addr_d = prev_addr_q;
    final_v0_d  = final_v0;
    done_d      = done;
    pass_d      = pass;
    fail_d      = fail;
    timeout_d   = timeout;
    halt_err_d  = halt_err;
    cyc_clr     = 1'b0;
    cyc_inc     = 1'b0;
    fetch_clr   = 1'b0;
    fetch_inc   = 1'b0;
    drain_clr   = 1'b0;
    drain_inc   = 1'b0;
    start       = active && (instr_address == RESET_VECTOR);
    halt_hit    = (instr_address == HALT_ADDR);
    timeout_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES));
    drain_last  = (drain_count == CNT_W'(DRAIN_CYCLES - 1));
    new_fetch   = (instr_address != prev_addr_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          cyc_clr     = 1'b1;
          cyc_inc     = 1'b1;
          fetch_clr   = 1'b1;
          fetch_inc   = 1'b1;
          prev_addr_d = instr_address;
        end
      end
      RUN: begin
        prev_addr_d = instr_address;
        if (halt_hit) begin
          state_d    = DRAIN;
          cyc_inc    = 1'b1;
          fetch_inc  = new_fetch;
          drain_clr  = 1'b1;
          final_v0_d = register_v0;
        end else if (!active) begin
          state_d    = DONE;
          cyc_inc    = 1'b1;
          fetch_inc  = new_fetch;
          done_d     = 1'b1;
          fail_d     = 1'b1;
          halt_err_d = 1'b1;
        end else if (timeout_hit) begin
          // Counters freeze at the limit rather than stepping past it.
          state_d   = DONE;
          done_d    = 1'b1;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cyc_inc   = 1'b1;
          fetch_inc = new_fetch;
        end
      end
      DRAIN: begin
        final_v0_d = register_v0;
        if (!active) begin
          state_d = CHECK;
        end else if (drain_last) begin
          state_d    = DONE;
          done_d     = 1'b1;
          fail_d     = 1'b1;
          halt_err_d = 1'b1;
        end else begin
          drain_inc = 1'b1;
        end
      end
      CHECK: begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = !check_en || (final_v0 == expected_v0);
        fail_d  = !pass_d;
      end
      DONE: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      prev_addr_q <= '0;
      final_v0    <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      halt_err    <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      prev_addr_q <= prev_addr_d;
      final_v0    <= final_v0_d;
      done        <= done_d;
      pass        <= pass_d;
      fail        <= fail_d;
      timeout     <= timeout_d;
      halt_err    <= halt_err_d;
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: expected verdicts are queued as each
// program is driven and compared once the monitor reports done.
module tb_cpu_run_monitor;

  localparam logic [31:0] RV     = 32'hBFC0_0000;
  localparam logic [31:0] V0_LUI = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] instr_address;
  logic [31:0] register_v0;
  logic [31:0] expected_v0;
  logic        check_en;
  logic        done, pass, fail, timeout, halt_err;
  logic [15:0] cycle_count, fetch_count;
  logic [31:0] final_v0;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       name;
    logic        pass, fail, timeout, halt_err;
    logic        chk_cnt;
    logic [15:0] cyc, fet;
    logic [31:0] v0;
  } exp_t;

  exp_t sb[$];

  cpu_run_monitor #(
    .TIMEOUT_CYCLES(20),
    .DRAIN_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr_address(instr_address), .register_v0(register_v0),
    .expected_v0(expected_v0), .check_en(check_en),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .halt_err(halt_err),
    .cycle_count(cycle_count), .fetch_count(fetch_count), .final_v0(final_v0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, clock them in, return at the following negedge.
  task automatic step(input logic [31:0] addr, input logic act, input logic ce);
    instr_address = addr;
    active        = act;
    clk_enable    = ce;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(32'h0, 1'b0, 1'b1);
    step(32'h0, 1'b0, 1'b1);
    reset = 1'b1;
  endtask

  task automatic push(input string name, input logic p, input logic f, input logic t,
                      input logic h, input logic cc, input logic [15:0] cyc,
                      input logic [15:0] fet, input logic [31:0] v0);
    exp_t e;
    e.name = name; e.pass = p; e.fail = f; e.timeout = t; e.halt_err = h;
    e.chk_cnt = cc; e.cyc = cyc; e.fet = fet; e.v0 = v0;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget, input logic ce_tog, input logic [31:0] addr,
                           input logic act, output int n);
    n = 0;
    while (!done && n < budget) begin
      if (ce_tog) step(32'h1234_5678, 1'b0, 1'b0);
      step(addr, act, 1'b1);
      n++;
    end
    check("done_bound", 32'(done), 32'd1);
  endtask

  task automatic compare_result();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".done"},     32'(done),     32'd1);
    check({e.name, ".pass"},     32'(pass),     32'(e.pass));
    check({e.name, ".fail"},     32'(fail),     32'(e.fail));
    check({e.name, ".timeout"},  32'(timeout),  32'(e.timeout));
    check({e.name, ".halt_err"}, 32'(halt_err), 32'(e.halt_err));
    if (e.chk_cnt) begin
      check({e.name, ".cycles"},   32'(cycle_count), 32'(e.cyc));
      check({e.name, ".fetches"},  32'(fetch_count), 32'(e.fet));
      check({e.name, ".final_v0"}, final_v0,         e.v0);
    end
  endtask

  // Three-instruction program ending at address 0; active falls after halt.
  task automatic run_lui(input logic chk, input logic [31:0] exp_v0, input logic ce_tog);
    logic [31:0] prog [4];
    int n;
    prog[0] = RV; prog[1] = RV + 32'd4; prog[2] = RV + 32'd8; prog[3] = 32'h0;
    check_en    = chk;
    expected_v0 = exp_v0;
    register_v0 = V0_LUI;
    for (int i = 0; i < 4; i++) begin
      if (ce_tog) step(32'h1234_5678, 1'b0, 1'b0);
      step(prog[i], 1'b1, 1'b1);
    end
    check("busy_flags", 32'({done, pass, fail}), 32'd0);
    wait_done(10, ce_tog, 32'h0, 1'b0, n);
  endtask

  initial begin
    int n;
    reset = 1'b0; clk_enable = 1'b1; active = 1'b0; instr_address = '0;
    register_v0 = '0; expected_v0 = '0; check_en = 1'b1;
    do_reset();
    check("rst.done",     32'(done),        32'd0);
    check("rst.flags",    32'({pass, fail, timeout, halt_err}), 32'd0);
    check("rst.cycles",   32'(cycle_count), 32'd0);
    check("rst.final_v0", final_v0,         32'd0);

    // Idle traffic away from the reset vector must not start a run.
    step(32'h0000_0040, 1'b1, 1'b1);
    step(RV, 1'b0, 1'b1);
    check("idle_hold", 32'(cycle_count), 32'd0);

    push("lui_pass", 1, 0, 0, 0, 1, 16'd4, 16'd4, V0_LUI);
    run_lui(1'b1, 32'd65536, 1'b0);
    compare_result();

    do_reset();
    push("lui_miss", 0, 1, 0, 0, 1, 16'd4, 16'd4, V0_LUI);
    run_lui(1'b1, 32'd1, 1'b0);
    compare_result();

    do_reset();
    push("lui_nochk", 1, 0, 0, 0, 1, 16'd4, 16'd4, V0_LUI);
    run_lui(1'b0, 32'd1, 1'b0);
    compare_result();

    // PC parks at BFC00004 and never halts.
    do_reset();
    push("timeout", 0, 1, 1, 0, 1, 16'd20, 16'd2, 32'd0);
    check_en = 1'b1;
    step(RV, 1'b1, 1'b1);
    wait_done(40, 1'b0, RV + 32'd4, 1'b1, n);
    compare_result();

    // Halt reached with active stuck high: four enabled drain cycles then fail.
    do_reset();
    push("drain_stuck", 0, 1, 0, 1, 1, 16'd4, 16'd4, V0_LUI);
    register_v0 = V0_LUI;
    step(RV, 1'b1, 1'b1);
    step(RV + 32'd4, 1'b1, 1'b1);
    step(RV + 32'd8, 1'b1, 1'b1);
    step(32'h0, 1'b1, 1'b1);
    wait_done(10, 1'b0, 32'h0, 1'b1, n);
    check("drain_len", 32'(n), 32'd4);
    compare_result();

    // active drops before the halt address is seen.
    do_reset();
    push("early_drop", 0, 1, 0, 1, 0, 16'd0, 16'd0, 32'd0);
    step(RV, 1'b1, 1'b1);
    step(RV + 32'd4, 1'b1, 1'b1);
    wait_done(5, 1'b0, RV + 32'd8, 1'b0, n);
    compare_result();

    // Stalled clock enable every other cycle must not change the outcome.
    do_reset();
    push("lui_stall", 1, 0, 0, 0, 1, 16'd4, 16'd4, V0_LUI);
    run_lui(1'b1, 32'd65536, 1'b1);
    compare_result();

    // Later activity after DONE is ignored.
    step(RV, 1'b1, 1'b1);
    step(RV + 32'd4, 1'b1, 1'b1);
    check("sticky.cycles", 32'(cycle_count), 32'd4);
    check("sticky.pass",   32'(pass),        32'd1);

    // Asynchronous reset mid-DONE clears everything without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async.done",     32'(done),        32'd0);
    check("async.pass",     32'(pass),        32'd0);
    check("async.cycles",   32'(cycle_count), 32'd0);
    check("async.fetches",  32'(fetch_count), 32'd0);
    check("async.final_v0", final_v0,         32'd0);
    @(negedge clk);
    reset = 1'b1;

    push("rerun", 1, 0, 0, 0, 1, 16'd4, 16'd4, V0_LUI);
    run_lui(1'b1, 32'd65536, 1'b0);
    compare_result();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
